data_devide_flex: RTL

Parametrised width down-converter: each IN_W-bit input word splits into up to RATIO OUT_W-bit beats on a valid/ready stream. It is the next-generation replacement for the fixed-ratio devider in the w4a8_gemm datapath, sitting between wide buffer reads and narrow PE/stream interfaces. New behaviour: a registered upstream ready, a holding stage for gapless throughput, selectable beat order, partial final words (beats_in), and last propagation.

---
 rtl/data_devide_pkg.sv | 31 +++
 rtl/data_devide_hold.sv | 67 ++++++
 rtl/data_devide_flex.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/data_devide_pkg.sv
// Shared types, beat-count normalisation and configuration checks
// for the data_devide_flex width down-converter.
package data_devide_pkg;

    localparam int MIN_RATIO  = 2;
    localparam int BEAT_CNT_W = 16;

    typedef logic [BEAT_CNT_W-1:0] beat_cnt_t;

    function automatic bit widths_ok(
        input int in_w,
        input int out_w
    );
        if (out_w <= 0) begin
            return 1'b0;
        end
        return (in_w % out_w == 0) && (in_w / out_w >= MIN_RATIO);
    endfunction

    // A zero or oversized request means "the whole word".
    function automatic beat_cnt_t normalise_beats(
        input beat_cnt_t req,
        input beat_cnt_t ratio
    );
        if (req == '0 || req > ratio) begin
            return ratio;
        end
        return req;
    endfunction

endpackage

// File: rtl/data_devide_hold.sv
// Holding register H: one full word with its beat count and last flag,
// filled while the shifter is busy and drained when the shifter finishes.
module data_devide_hold
    import data_devide_pkg::*;
#(
    parameter int IN_W = 1024,
    parameter int CW   = 3
) (
    input  logic            clk,
    input  logic            areset_n,
    input  logic            clear_i,
    input  logic            load_i,
    input  logic            drain_i,
    input  logic [IN_W-1:0] data_i,
    input  logic [CW-1:0]   n_i,
    input  logic            last_i,
    output logic            valid_o,
    output logic [IN_W-1:0] data_o,
    output logic [CW-1:0]   n_o,
    output logic            last_o
);

    logic            valid_q, valid_d;
    logic [IN_W-1:0] data_q, data_d;
    logic [CW-1:0]   n_q, n_d;
    logic            last_q, last_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        n_d     = n_q;
        last_d  = last_q;
        if (clear_i) begin
            valid_d = 1'b0;
            data_d  = '0;
            n_d     = '0;
            last_d  = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            n_d     = n_i;
            last_d  = last_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            n_q     <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            n_q     <= n_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign n_o     = n_q;
    assign last_o  = last_q;

endmodule

// File: rtl/data_devide_flex.sv
// Width down-converter: splits IN_W words into up to RATIO OUT_W beats
// through a shifter stage S backed by a holding register H.
module data_devide_flex
    import data_devide_pkg::*;
#(
    parameter int IN_W      = 1024,
    parameter int OUT_W     = 256,
    parameter int RATIO     = IN_W / OUT_W,
    parameter bit MSB_FIRST = 1'b0,
    parameter int CW        = $clog2(RATIO) + 1
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             ap_start,
    input  logic [IN_W-1:0]  data_in,
    input  logic             valid_in,
    input  logic             last_in,
    input  logic [CW-1:0]    beats_in,
    output logic             ready_out,
    output logic [OUT_W-1:0] data_out,
    output logic             valid_out,
    output logic             last_out,
    input  logic             ready_in,
    output logic             busy
);

    localparam int  SW     = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam bit  CFG_OK = widths_ok(IN_W, OUT_W) && (RATIO == IN_W / OUT_W);

    if (!CFG_OK) begin : g_bad_cfg
        $error("data_devide_flex: IN_W must be a multiple of OUT_W with RATIO >= 2");
    end

    logic             s_valid_q, s_valid_d;
    logic [IN_W-1:0]  s_data_q, s_data_d;
    logic [CW-1:0]    s_n_q, s_n_d;
    logic [CW-1:0]    s_k_q, s_k_d;
    logic             s_last_q, s_last_d;

    logic             h_valid;
    logic [IN_W-1:0]  h_data;
    logic [CW-1:0]    h_n;
    logic             h_last;

    logic [CW-1:0]    n_in;
    logic             fire_in;
    logic             fire_out;
    logic             s_last_beat;
    logic             s_done;
    logic             h_load;
    logic             h_drain;

    logic [RATIO-1:0][OUT_W-1:0] s_beats;
    logic [SW-1:0]               beat_sel;

    assign n_in = CW'(normalise_beats(beat_cnt_t'(beats_in), beat_cnt_t'(RATIO)));

    // ready_out depends only on registered H state and ap_start.
    assign ready_out   = !h_valid && !ap_start;
    assign valid_out   = s_valid_q;
    assign busy        = s_valid_q || h_valid;

    assign fire_in     = valid_in && ready_out;
    assign fire_out    = valid_out && ready_in;
    assign s_last_beat = s_valid_q && (s_k_q == s_n_q - CW'(1));
    assign s_done      = fire_out && s_last_beat;
    assign h_load      = fire_in && s_valid_q && !s_done;
    assign h_drain     = s_done && h_valid;

    assign s_beats  = s_data_q;
    assign beat_sel = MSB_FIRST ? (SW'(RATIO - 1) - SW'(s_k_q)) : SW'(s_k_q);
    assign data_out = s_beats[beat_sel];
    assign last_out = s_last_beat && s_last_q;

    always_comb begin
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        s_n_d     = s_n_q;
        s_k_d     = s_k_q;
        s_last_d  = s_last_q;
        if (ap_start) begin
            s_valid_d = 1'b0;
            s_data_d  = '0;
            s_n_d     = '0;
            s_k_d     = '0;
            s_last_d  = 1'b0;
        end else if (fire_out && !s_last_beat) begin
            s_k_d = s_k_q + CW'(1);
        end else if (s_done || (!s_valid_q && fire_in)) begin
            s_k_d = '0;
            if (h_valid) begin
                s_valid_d = 1'b1;
                s_data_d  = h_data;
                s_n_d     = h_n;
                s_last_d  = h_last;
            end else if (fire_in) begin
                s_valid_d = 1'b1;
                s_data_d  = data_in;
                s_n_d     = n_in;
                s_last_d  = last_in;
            end else begin
                s_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
            s_n_q     <= '0;
            s_k_q     <= '0;
            s_last_q  <= 1'b0;
        end else begin
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
            s_n_q     <= s_n_d;
            s_k_q     <= s_k_d;
            s_last_q  <= s_last_d;
        end
    end

    data_devide_hold #(
        .IN_W (IN_W),
        .CW   (CW)
    ) u_hold (
        .clk      (clk),
        .areset_n (areset_n),
        .clear_i  (ap_start),
        .load_i   (h_load),
        .drain_i  (h_drain),
        .data_i   (data_in),
        .n_i      (n_in),
        .last_i   (last_in),
        .valid_o  (h_valid),
        .data_o   (h_data),
        .n_o      (h_n),
        .last_o   (h_last)
    );

endmodule
